// File: rtl/snow64_mem_arbiter_pkg.sv
// rtl/snow64_mem_arbiter_pkg.sv - state and port-group types for the snow64 memory arbiter
`ifndef WIDTH__SNOW64_ICACHE_LINE_DATA
`define WIDTH__SNOW64_ICACHE_LINE_DATA 256
`endif
`ifndef WIDTH__SNOW64_CPU_ADDR
`define WIDTH__SNOW64_CPU_ADDR 64
`endif

package PkgSnow64MemArbiter;

  localparam int LineW = `WIDTH__SNOW64_ICACHE_LINE_DATA;
  localparam int AddrW = `WIDTH__SNOW64_CPU_ADDR;

  typedef enum logic [1:0] {
    StIdle,
    StWaitInstr,
    StWaitData
  } state_e;

  typedef struct packed {
    logic             valid;
    logic [AddrW-1:0] addr;
  } instr_slot_t;

  typedef struct packed {
    logic             valid;
    logic [AddrW-1:0] addr;
    logic             write;
    logic [LineW-1:0] wdata;
  } data_slot_t;

  typedef struct packed {
    logic             req;
    logic [AddrW-1:0] addr;
    logic             write;
    logic [LineW-1:0] wdata;
  } mem_port_t;

endpackage

// File: rtl/snow64_mem_arbiter.sv
// rtl/snow64_mem_arbiter.sv - round-robin arbiter sharing one memory port between icache and data side
module snow64_mem_arbiter
  import PkgSnow64MemArbiter::*;
#(
  parameter int LINE_W = `WIDTH__SNOW64_ICACHE_LINE_DATA,
  parameter int ADDR_W = `WIDTH__SNOW64_CPU_ADDR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_instr_req,
  input  logic [ADDR_W-1:0] in_instr_addr,
  output logic              out_instr_valid,
  output logic [LINE_W-1:0] out_instr_data,
  input  logic              in_data_req,
  input  logic [ADDR_W-1:0] in_data_addr,
  input  logic              in_data_write,
  input  logic [LINE_W-1:0] in_data_wdata,
  output logic              out_data_valid,
  output logic [LINE_W-1:0] out_data_rdata,
  output logic              out_mem_req,
  output logic [ADDR_W-1:0] out_mem_addr,
  output logic              out_mem_write,
  output logic [LINE_W-1:0] out_mem_wdata,
  input  logic              in_mem_valid,
  input  logic [LINE_W-1:0] in_mem_rdata
);

  state_e            state_q, state_d;
  instr_slot_t       islot_q, islot_d;
  data_slot_t        dslot_q, dslot_d;
  mem_port_t         mem_q, mem_d;
  logic              last_data_q, last_data_d;
  logic              ivalid_q, ivalid_d;
  logic [LINE_W-1:0] idata_q, idata_d;
  logic              dvalid_q, dvalid_d;
  logic [LINE_W-1:0] drdata_q, drdata_d;

  logic grant_instr, grant_data, accept_instr, accept_data;

  // A port whose transaction completes this very cycle may already queue its next request.
  always_comb begin
    grant_instr  = islot_q.valid && (!dslot_q.valid || last_data_q);
    grant_data   = dslot_q.valid && !grant_instr;
    accept_instr = in_instr_req && !islot_q.valid && !(state_q == StWaitInstr && !in_mem_valid);
    accept_data  = in_data_req && !dslot_q.valid && !(state_q == StWaitData && !in_mem_valid);
  end

  always_comb begin
    state_d     = state_q;
    islot_d     = islot_q;
    dslot_d     = dslot_q;
    mem_d       = mem_q;
    mem_d.req   = 1'b0;
    last_data_d = last_data_q;
    ivalid_d    = 1'b0;
    idata_d     = idata_q;
    dvalid_d    = 1'b0;
    drdata_d    = drdata_q;
    unique case (state_q)
      StIdle: begin
        if (grant_instr) begin
          mem_d         = '{req: 1'b1, addr: islot_q.addr, write: 1'b0, wdata: '0};
          islot_d.valid = 1'b0;
          last_data_d   = 1'b0;
          state_d       = StWaitInstr;
        end else if (grant_data) begin
          mem_d         = '{req: 1'b1, addr: dslot_q.addr, write: dslot_q.write, wdata: dslot_q.wdata};
          dslot_d.valid = 1'b0;
          last_data_d   = 1'b1;
          state_d       = StWaitData;
        end
      end
      StWaitInstr: begin
        if (in_mem_valid) begin
          ivalid_d = 1'b1;
          idata_d  = in_mem_rdata;
          state_d  = StIdle;
        end
      end
      StWaitData: begin
        if (in_mem_valid) begin
          dvalid_d = 1'b1;
          drdata_d = in_mem_rdata;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (accept_instr) islot_d = '{valid: 1'b1, addr: in_instr_addr};
    if (accept_data) begin
      dslot_d = '{valid: 1'b1, addr: in_data_addr, write: in_data_write, wdata: in_data_wdata};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      islot_q     <= '0;
      dslot_q     <= '0;
      mem_q       <= '0;
      last_data_q <= 1'b1;
      ivalid_q    <= 1'b0;
      idata_q     <= '0;
      dvalid_q    <= 1'b0;
      drdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      islot_q     <= islot_d;
      dslot_q     <= dslot_d;
      mem_q       <= mem_d;
      last_data_q <= last_data_d;
      ivalid_q    <= ivalid_d;
      idata_q     <= idata_d;
      dvalid_q    <= dvalid_d;
      drdata_q    <= drdata_d;
    end
  end

  assign out_instr_valid = ivalid_q;
  assign out_instr_data  = idata_q;
  assign out_data_valid  = dvalid_q;
  assign out_data_rdata  = drdata_q;
  assign out_mem_req     = mem_q.req;
  assign out_mem_addr    = mem_q.addr;
  assign out_mem_write   = mem_q.write;
  assign out_mem_wdata   = mem_q.wdata;

endmodule

// File: tb/tb_snow64_mem_arbiter.sv
// tb/tb_snow64_mem_arbiter.sv - randomized bench for snow64_mem_arbiter against a port-level reference model
module tb_snow64_mem_arbiter;

  localparam int LW = 256;
  localparam int AW = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_instr_req, in_data_req, in_data_write, in_mem_valid;
  logic [AW-1:0] in_instr_addr, in_data_addr;
  logic [LW-1:0] in_data_wdata, in_mem_rdata;
  logic          out_instr_valid, out_data_valid, out_mem_req, out_mem_write;
  logic [LW-1:0] out_instr_data, out_data_rdata, out_mem_wdata;
  logic [AW-1:0] out_mem_addr;

  always #5 clk = ~clk;

  snow64_mem_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_instr_req   (in_instr_req),
    .in_instr_addr  (in_instr_addr),
    .out_instr_valid(out_instr_valid),
    .out_instr_data (out_instr_data),
    .in_data_req    (in_data_req),
    .in_data_addr   (in_data_addr),
    .in_data_write  (in_data_write),
    .in_data_wdata  (in_data_wdata),
    .out_data_valid (out_data_valid),
    .out_data_rdata (out_data_rdata),
    .out_mem_req    (out_mem_req),
    .out_mem_addr   (out_mem_addr),
    .out_mem_write  (out_mem_write),
    .out_mem_wdata  (out_mem_wdata),
    .in_mem_valid   (in_mem_valid),
    .in_mem_rdata   (in_mem_rdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Port 0 = instr, port 1 = data; owner -1 means no memory transaction outstanding.
  bit            pend[2];
  logic [AW-1:0] p_addr[2];
  bit            p_wr[2];
  logic [LW-1:0] p_wd[2];
  int            owner, last, cnt;
  bit            inflight_wr, ddata_known, did_reset;
  bit            e_mreq, e_mwr, e_ival, e_dval;
  logic [AW-1:0] e_maddr;
  logic [LW-1:0] e_mwd, e_idata, e_ddata;

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      pend[p] = 0; p_addr[p] = '0; p_wr[p] = 0; p_wd[p] = '0;
    end
    owner = -1; last = 1; cnt = 0; inflight_wr = 0; ddata_known = 1;
    e_mreq = 0; e_mwr = 0; e_ival = 0; e_dval = 0;
    e_maddr = '0; e_mwd = '0; e_idata = '0; e_ddata = '0;
  endtask

  task automatic zero_inputs();
    in_instr_req = 0; in_instr_addr = '0; in_data_req = 0; in_data_addr = '0;
    in_data_write = 0; in_data_wdata = '0; in_mem_valid = 0; in_mem_rdata = '0;
  endtask

  task automatic compare_outputs();
    check("mem_req", out_mem_req, e_mreq);
    check("mem_addr", out_mem_addr, e_maddr);
    check("mem_write", out_mem_write, e_mwr);
    if (e_mwr) check("mem_wdata", out_mem_wdata, e_mwd);
    check("instr_valid", out_instr_valid, e_ival);
    check("instr_data", out_instr_data, e_idata);
    check("data_valid", out_data_valid, e_dval);
    if (ddata_known) check("data_rdata", out_data_rdata, e_ddata);
  endtask

  task automatic drive_inputs();
    in_instr_req  = ($urandom_range(0, 3) == 0);
    in_instr_addr = {$urandom, $urandom};
    in_data_req   = ($urandom_range(0, 3) == 0);
    in_data_addr  = {$urandom, $urandom};
    in_data_write = $urandom_range(0, 1);
    in_data_wdata = rand_line();
    in_mem_rdata  = rand_line();
    in_mem_valid  = 0;
    if (owner != -1) begin
      if (cnt == 0) in_mem_valid = 1;
      else cnt--;
    end else if ($urandom_range(0, 15) == 0) begin
      in_mem_valid = 1;
    end
  endtask

  // Advances the model across one clock edge; e_* then describe the DUT outputs for the next cycle.
  task automatic model_step();
    bit old_pend[2];
    bit acc[2];
    int c;
    old_pend = pend;
    e_mreq = 0; e_ival = 0; e_dval = 0;
    acc[0] = in_instr_req && !old_pend[0] && !(owner == 0 && !in_mem_valid);
    acc[1] = in_data_req && !old_pend[1] && !(owner == 1 && !in_mem_valid);
    if (owner == -1) begin
      c = -1;
      if (old_pend[0] && old_pend[1]) c = (last == 1) ? 0 : 1;
      else if (old_pend[0]) c = 0;
      else if (old_pend[1]) c = 1;
      if (c >= 0) begin
        e_mreq = 1; e_maddr = p_addr[c]; e_mwr = p_wr[c]; e_mwd = p_wd[c];
        inflight_wr = p_wr[c]; pend[c] = 0; owner = c; last = c;
        cnt = $urandom_range(0, 3);
      end
    end else if (in_mem_valid) begin
      if (owner == 0) begin
        e_ival = 1; e_idata = in_mem_rdata;
      end else begin
        e_dval = 1; e_ddata = in_mem_rdata; ddata_known = !inflight_wr;
      end
      owner = -1;
    end
    if (acc[0]) begin
      pend[0] = 1; p_addr[0] = in_instr_addr; p_wr[0] = 0; p_wd[0] = '0;
    end
    if (acc[1]) begin
      pend[1] = 1; p_addr[1] = in_data_addr; p_wr[1] = in_data_write; p_wd[1] = in_data_wdata;
    end
  endtask

  initial begin
    did_reset = 0;
    model_reset();
    zero_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    compare_outputs();
    rst_n = 1;
    for (int i = 0; i < 4000; i++) begin
      if (i > 0) begin
        @(negedge clk);
        compare_outputs();
      end
      if (!did_reset && i >= 2000 && owner == 1) begin
        did_reset = 1;
        rst_n = 0;
        #1;
        model_reset();
        compare_outputs();
        zero_inputs();
        @(negedge clk);
        compare_outputs();
        rst_n = 1;
        in_mem_valid = 1;
        in_mem_rdata = rand_line();
        model_step();
        continue;
      end
      drive_inputs();
      model_step();
    end
    check("reset_exercised", did_reset, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
